// File: rtl/bin_erosion_pkg.sv
// Shared types and constants for the binary-erosion line-buffer controller.
package bin_erosion_pkg;

  localparam int unsigned ImgWidthDefault = 640;

  // Row-fill phase of the current frame.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill0 = 2'd1,
    StFill1 = 2'd2,
    StRun   = 2'd3
  } state_e;

  // Column counter width; at least one bit even for the smallest legal width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bin_erosion_col_cnt.sv
// Column counter with wrap pulse and first/last-column flags.
module bin_erosion_col_cnt
  import bin_erosion_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = ImgWidthDefault,
  parameter int unsigned CNT_W     = cnt_width(IMG_WIDTH)
) (
  input  logic clk,
  input  logic tb_rst,
  input  logic clr,
  input  logic inc,
  output logic wrap,
  output logic first,
  output logic last
);

  localparam logic [CNT_W-1:0] LastCol = CNT_W'(IMG_WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == LastCol);
  assign wrap  = inc & last;

  // Next count: clear wins over increment; wrap at the last column.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bin_erosion_linebuf_ctrl.sv
// Sequences two external 1-bit FIFOs as cascaded row delays and emits an
// aligned {row n-2, row n-1, row n} column for a 3x3 erosion window.
// Optional feature macro: BIN_EROSION_BORDER_EN adds col_first/col_last flags.
module bin_erosion_linebuf_ctrl
  import bin_erosion_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = ImgWidthDefault,
  parameter int unsigned CNT_W     = cnt_width(IMG_WIDTH)
) (
  input  logic       clk,
  input  logic       tb_rst,
  input  logic       frame_start,
  input  logic       pix_vld,
  input  logic       pix_data,
  output logic       fifo_rst,
  output logic       f0_wr_en,
  output logic       f0_wr_data,
  output logic       f0_rd_en,
  input  logic       f0_rd_data,
  input  logic       f0_empty,
  output logic       f1_wr_en,
  output logic       f1_wr_data,
  output logic       f1_rd_en,
  input  logic       f1_rd_data,
  input  logic       f1_empty,
  output logic       col_vld,
  output logic [2:0] col_data,
`ifdef BIN_EROSION_BORDER_EN
  output logic       col_first,
  output logic       col_last,
`endif
  output logic       underflow_err
);

  state_e state_q, state_d;
  logic   accept, rd0, rd1, wrap, first, last;
  logic   rd0_q, col_vld_q, pix_q, uf_q, uf_d;

  // A pixel is taken only in an active state and never alongside frame_start.
  assign accept = pix_vld & (state_q != StIdle) & ~frame_start;
  assign rd0    = accept & ((state_q == StFill1) | (state_q == StRun));
  assign rd1    = accept & (state_q == StRun);

  bin_erosion_col_cnt #(
    .IMG_WIDTH (IMG_WIDTH),
    .CNT_W     (CNT_W)
  ) u_col_cnt (
    .clk    (clk),
    .tb_rst (tb_rst),
    .clr    (frame_start),
    .inc    (accept),
    .wrap   (wrap),
    .first  (first),
    .last   (last)
  );

  // Next-state: frame_start aborts from anywhere; row wraps advance the fill phase.
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = StFill0;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StFill0: if (wrap) state_d = StFill1;
        StFill1: if (wrap) state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Sticky underflow, cleared by a new frame.
  always_comb begin
    uf_d = uf_q | (rd0 & f0_empty) | (rd1 & f1_empty);
    if (frame_start) uf_d = 1'b0;
  end

  // State and one-cycle pipeline matching the FIFO read latency.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q   <= StIdle;
      rd0_q     <= 1'b0;
      col_vld_q <= 1'b0;
      pix_q     <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd0_q     <= rd0;
      col_vld_q <= rd1;
      if (accept) pix_q <= pix_data;
      uf_q      <= uf_d;
    end
  end

  // Delayed actions are dropped in an abort cycle so they cannot hit the reset FIFOs.
  assign fifo_rst      = tb_rst | frame_start;
  assign f0_wr_en      = accept;
  assign f0_wr_data    = accept & pix_data;
  assign f0_rd_en      = rd0;
  assign f1_rd_en      = rd1;
  assign f1_wr_en      = rd0_q & ~frame_start;
  assign f1_wr_data    = f1_wr_en & f0_rd_data;
  assign col_vld       = col_vld_q & ~frame_start;
  assign col_data      = col_vld ? {f1_rd_data, f0_rd_data, pix_q} : 3'b000;
  assign underflow_err = uf_q;

`ifdef BIN_EROSION_BORDER_EN
  logic first_q, last_q;

  // Border flags travel with the column they describe.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      first_q <= rd1 & first;
      last_q  <= rd1 & last;
    end
  end

  assign col_first = first_q & ~frame_start;
  assign col_last  = last_q & ~frame_start;
`else
  logic unused_border;
  assign unused_border = first ^ last;
`endif

endmodule

// File: tb/tb_bin_erosion_linebuf_ctrl.sv
// Self-checking bench: behavioural FIFO models plus an image-array reference.
module tb_bin_erosion_linebuf_ctrl;

  localparam int unsigned W = 8;
  localparam int MaxRows = 32;

  logic clk = 1'b0, tb_rst = 1'b1;
  logic frame_start = 1'b0, pix_vld = 1'b0, pix_data = 1'b0;
  logic fifo_rst, f0_wr_en, f0_wr_data, f0_rd_en, f1_wr_en, f1_wr_data, f1_rd_en;
  logic col_vld, underflow_err;
  logic [2:0] col_data;
  logic rd0_m = 1'b0, rd1_m = 1'b0, e0_m = 1'b1, e1_m = 1'b1, force1 = 1'b0;
  logic f0_rd_data, f1_rd_data, f0_empty, f1_empty;
`ifdef BIN_EROSION_BORDER_EN
  logic col_first, col_last;
`endif

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign f0_rd_data = rd0_m;
  assign f1_rd_data = rd1_m;
  assign f0_empty   = e0_m;
  assign f1_empty   = e1_m | force1;

  bin_erosion_linebuf_ctrl #(.IMG_WIDTH(W)) dut (
    .clk           (clk),
    .tb_rst        (tb_rst),
    .frame_start   (frame_start),
    .pix_vld       (pix_vld),
    .pix_data      (pix_data),
    .fifo_rst      (fifo_rst),
    .f0_wr_en      (f0_wr_en),
    .f0_wr_data    (f0_wr_data),
    .f0_rd_en      (f0_rd_en),
    .f0_rd_data    (f0_rd_data),
    .f0_empty      (f0_empty),
    .f1_wr_en      (f1_wr_en),
    .f1_wr_data    (f1_wr_data),
    .f1_rd_en      (f1_rd_en),
    .f1_rd_data    (f1_rd_data),
    .f1_empty      (f1_empty),
    .col_vld       (col_vld),
    .col_data      (col_data),
`ifdef BIN_EROSION_BORDER_EN
    .col_first     (col_first),
    .col_last      (col_last),
`endif
    .underflow_err (underflow_err)
  );

  // Behavioural 1-bit FIFOs: data appears the cycle after a read.
  logic q0[$], q1[$];
  always @(posedge clk) begin
    if (fifo_rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (f0_rd_en) rd0_m <= (q0.size() > 0) ? q0.pop_front() : 1'b0;
      if (f1_rd_en) rd1_m <= (q1.size() > 0) ? q1.pop_front() : 1'b0;
      if (f0_wr_en) q0.push_back(f0_wr_data);
      if (f1_wr_en) q1.push_back(f1_wr_data);
    end
    e0_m <= (q0.size() == 0);
    e1_m <= (q1.size() == 0);
  end

  // Reference model: the image so far, indexed by row and column.
  logic img[MaxRows][W];
  int   row = 0, col = 0;
  bit   active = 0, pend_col = 0, pend_wr1 = 0;
  logic [2:0] pend_data = 3'b000;
  logic [5:0] e_en, obs_en;   // {fifo_rst, f0_wr, f0_rd, f1_wr, f1_rd, col_vld}
  logic [2:0] e_data, obs_data;
  logic obs_uf;

  // One cycle: drive inputs, form expectations, sample outputs, advance the model.
  task automatic step(input logic fs, input logic vld, input logic d);
    bit acc;
    @(negedge clk);
    frame_start = fs;
    pix_vld     = vld;
    pix_data    = d;
    acc = vld && active && !fs;
    e_en[0] = pend_col && !fs;
    e_data  = e_en[0] ? pend_data : 3'b000;
    e_en[5:1] = {fs, acc, acc && row >= 1, pend_wr1 && !fs, acc && row >= 2};
    #1;
    obs_en   = {fifo_rst, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en, col_vld};
    obs_data = col_data;
    obs_uf   = underflow_err;
    pend_wr1 = acc && row >= 1;
    pend_col = acc && row >= 2;
    if (fs) begin
      active = 1;
      row = 0;
      col = 0;
    end else if (acc) begin
      img[row][col] = d;
      if (row >= 2) pend_data = {img[row-2][col], img[row-1][col], d};
      col++;
      if (col == W) begin
        col = 0;
        if (row < MaxRows - 1) row++;
      end
    end
  endtask

  task automatic test_reset();
    pix_vld = 1'b1;
    #1;
    checks++;
    if ({fifo_rst, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en, col_vld, col_data, underflow_err}
        !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got fifo_rst=%b wr0=%b rd0=%b wr1=%b rd1=%b cv=%b cd=%b uf=%b, want only fifo_rst=1",
               fifo_rst, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en, col_vld, col_data, underflow_err);
    end
    @(negedge clk);
    tb_rst  = 1'b0;
    pix_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (obs_en !== 6'b0) begin
        errors++;
        $display("FAIL idle_ignores_pix: got %b want 000000", obs_en);
      end
    end
  endtask

  // Row 0 (0xAA): writes only, single-cycle fifo_rst.
  task automatic test_fill0();
    logic [7:0] pat;
    pat = 8'hAA;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_en !== 6'b100000) begin
      errors++;
      $display("FAIL fill0_frame_start: got %b want 100000", obs_en);
    end
    for (int c = 0; c < W; c++) begin
      step(1'b0, 1'b1, pat[7-c]);
      checks++;
      if (obs_en !== 6'b010000 || obs_en !== e_en) begin
        errors++;
        $display("FAIL fill0_col%0d: got %b want 010000", c, obs_en);
      end
    end
  endtask

  // Rows 1 (0xCC) and 2 (0xF0), continuous, then one idle cycle for the last column.
  task automatic test_rows();
    logic [15:0] pat;
    pat = 16'hCCF0;
    for (int i = 0; i < 2 * W + 1; i++) begin
      step(1'b0, i < 2 * W, (i < 2 * W) ? pat[15-i] : 1'b0);
      checks++;
      if (obs_en !== e_en || obs_data !== e_data) begin
        errors++;
        $display("FAIL rows_cycle%0d: got en=%b col=%b want en=%b col=%b",
                 i, obs_en, obs_data, e_en, e_data);
      end
    end
  endtask

  // Fresh frame; row 2 arrives with pix_vld every other cycle.
  task automatic test_gaps();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4 * W + 1; i++) begin
      if (i < 2 * W) step(1'b0, 1'b1, 1'($urandom));
      else step(1'b0, (i % 2) == 0 && i < 4 * W, 1'($urandom));
      checks++;
      if (obs_en !== e_en || obs_data !== e_data) begin
        errors++;
        $display("FAIL gaps_cycle%0d: got en=%b col=%b want en=%b col=%b",
                 i, obs_en, obs_data, e_en, e_data);
      end
    end
  endtask

  // Abort five pixels into row 3; the next row must not produce columns.
  task automatic test_abort();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * W + 5; i++) step(1'b0, 1'b1, 1'($urandom));
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (obs_en !== 6'b100000) begin
      errors++;
      $display("FAIL abort_pulse: got %b want 100000", obs_en);
    end
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, 1'($urandom));
      checks++;
      if (obs_en[0] !== 1'b0 || obs_uf !== 1'b0 || obs_en !== e_en) begin
        errors++;
        $display("FAIL abort_after%0d: got en=%b uf=%b want en=%b uf=0", i, obs_en, obs_uf, e_en);
      end
    end
  endtask

  // Forced f1 empty on a RUN read sets a sticky error until the next frame.
  task automatic test_underflow();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * W; i++) step(1'b0, 1'b1, 1'($urandom));
    checks++;
    if (obs_uf !== 1'b0) begin
      errors++;
      $display("FAIL uf_before: got %b want 0", obs_uf);
    end
    force1 = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 force1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, i[0], 1'b0);
      checks++;
      if (obs_uf !== 1'b1) begin
        errors++;
        $display("FAIL uf_sticky%0d: got %b want 1", i, obs_uf);
      end
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_uf !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear: got %b want 0", obs_uf);
    end
  endtask

  // Random pixels, gaps and occasional aborts against the image model.
  task automatic test_random();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 199) == 0) || row >= 20, $urandom_range(0, 3) != 0,
           1'($urandom));
      checks++;
      if (obs_en !== e_en || obs_data !== e_data || obs_uf !== 1'b0) begin
        errors++;
        $display("FAIL random_cycle%0d: got en=%b col=%b uf=%b want en=%b col=%b uf=0",
                 i, obs_en, obs_data, obs_uf, e_en, e_data);
      end
    end
  endtask

  // Asynchronous reset while a column is being presented.
  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * W + 3; i++) step(1'b0, 1'b1, 1'($urandom));
    @(posedge clk);
    #2;
    checks++;
    if (col_vld !== 1'b1) begin
      errors++;
      $display("FAIL arst_precond: col_vld got %b want 1", col_vld);
    end
    tb_rst = 1'b1;
    #1;
    checks++;
    if ({fifo_rst, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en, col_vld, col_data, underflow_err}
        !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL arst_outputs: got rst=%b wr0=%b rd0=%b wr1=%b rd1=%b cv=%b cd=%b uf=%b",
               fifo_rst, f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en, col_vld, col_data, underflow_err);
    end
    @(negedge clk);
    @(negedge clk);
    tb_rst   = 1'b0;
    active   = 0;
    pend_col = 0;
    pend_wr1 = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (obs_en !== 6'b0) begin
        errors++;
        $display("FAIL arst_idle%0d: got %b want 000000", i, obs_en);
      end
    end
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * W + 1; i++) begin
      step(1'b0, i < 3 * W, 1'($urandom));
      checks++;
      if (obs_en !== e_en || obs_data !== e_data) begin
        errors++;
        $display("FAIL arst_resume%0d: got en=%b col=%b want en=%b col=%b",
                 i, obs_en, obs_data, e_en, e_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill0();
    test_rows();
    test_gaps();
    test_abort();
    test_underflow();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
